// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, encodings, control bundle and state type
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;
    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } immSrc_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } resultSrc_e;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNCT  = 2'b10,
        ALU_MULDIV = 2'b11
    } aluOp_e;

    typedef struct packed {
        logic       regWrite;
        immSrc_e    immSrc;
        logic       aluSrc;
        logic       aluSrcA;
        logic       memWrite;
        resultSrc_e resultSrc;
        aluOp_e     aluOp;
        logic       jump;
        logic       jalr;
        logic       branch;
        logic       mulDiv;
        logic       illegal;
        logic       sys;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage

// File: rtl/ctrl_decode_comb.sv
// rtl/ctrl_decode_comb.sv - combinational RV32I(+M) instruction to control bundle decode
module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       illegal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Classify the word and fill its bundle; any reject collapses to a bare Illegal flag.
    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        case (opcode)
            OP_LOAD: begin
                illegal          = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
                ctrl.regWrite    = 1'b1;
                ctrl.immSrc      = IMM_I;
                ctrl.aluSrc      = 1'b1;
                ctrl.resultSrc   = RES_MEM;
                ctrl.aluOp       = ALU_ADD;
            end
            OP_STORE: begin
                illegal          = (funct3 > 3'b010);
                ctrl.immSrc      = IMM_S;
                ctrl.aluSrc      = 1'b1;
                ctrl.memWrite    = 1'b1;
            end
            OP_RTYPE: begin
                ctrl.regWrite = 1'b1;
                if ((funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
                    ctrl.aluOp = ALU_FUNCT;
                end else if ((funct7 == F7_MULDIV) && ENABLE_M) begin
                    ctrl.aluOp  = ALU_MULDIV;
                    ctrl.mulDiv = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_IALU: begin
                ctrl.regWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.aluOp    = ALU_FUNCT;
            end
            OP_BRANCH: begin
                illegal     = (funct3 == 3'b010) || (funct3 == 3'b011);
                ctrl.immSrc = IMM_B;
                ctrl.aluOp  = ALU_BRANCH;
                ctrl.branch = 1'b1;
            end
            OP_LUI: begin
                ctrl.regWrite  = 1'b1;
                ctrl.immSrc    = IMM_U;
                ctrl.resultSrc = RES_IMM;
            end
            OP_AUIPC: begin
                ctrl.regWrite = 1'b1;
                ctrl.immSrc   = IMM_U;
                ctrl.aluSrcA  = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.aluOp    = ALU_ADD;
            end
            OP_JAL: begin
                ctrl.regWrite  = 1'b1;
                ctrl.immSrc    = IMM_J;
                ctrl.resultSrc = RES_PC4;
                ctrl.jump      = 1'b1;
            end
            OP_JALR: begin
                illegal        = (funct3 != 3'b000);
                ctrl.regWrite  = 1'b1;
                ctrl.immSrc    = IMM_I;
                ctrl.aluSrc    = 1'b1;
                ctrl.resultSrc = RES_PC4;
                ctrl.jalr      = 1'b1;
            end
            OP_FENCE: begin
                ctrl = '0;
            end
            OP_SYSTEM: begin
                ctrl.sys = 1'b1;
                illegal  = !((instr == ECALL_WORD) || (instr == EBREAK_WORD));
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        if (illegal) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/ctrl_pipe_stage.sv
// rtl/ctrl_pipe_stage.sv - one valid/ready register slot of the decode pipeline
module ctrl_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         inValid,
    output logic         inReady,
    input  logic [W-1:0] inData,
    output logic         outValid,
    input  logic         outReady,
    output logic [W-1:0] outData
);

    assign inReady = !outValid || outReady;

    // Hold the slot until downstream takes it; a flush empties it regardless of handshakes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outValid <= 1'b0;
            outData  <= '0;
        end else if (flush) begin
            outValid <= 1'b0;
        end else if (inReady) begin
            outValid <= inValid;
            if (inValid) begin
                outData <= inData;
            end
        end
    end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// rtl/ctrl_decode_pipe.sv - registered, back-pressured control decode with RUN/HALT issue control
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int DEPTH        = 1,
    parameter bit ENABLE_M     = 1'b1,
    parameter int TAG_W        = 32,
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      instr_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] tag_o,
    output logic             RegWrite,
    output logic [2:0]       ImmSrc,
    output logic             ALUSrc,
    output logic             ALUSrcA,
    output logic             MemWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUOp,
    output logic             Jump,
    output logic             Jalr,
    output logic             Branch,
    output logic             MulDiv,
    output logic             Illegal,
    output logic             Sys,
    output logic             halt,
    input  logic             resume
);

    localparam int W = CTRL_W + TAG_W;

    ctrl_t          decCtrl;
    ctrl_t          outCtrl;
    state_e         state;
    state_e         stateNext;
    logic           running;
    logic           accept;
    logic           trap;
    logic [W-1:0]   outWord;

    logic           stageValid [DEPTH+1];
    logic           stageReady [DEPTH+1];
    logic [W-1:0]   stageData  [DEPTH+1];

    ctrl_decode_comb #(.ENABLE_M(ENABLE_M)) uDecode (
        .instr (instr_i),
        .ctrl  (decCtrl)
    );

    assign running  = (state == ST_RUN);
    assign in_ready = stageReady[0] && running && !flush;
    assign accept   = in_valid && in_ready;
    assign trap     = decCtrl.illegal || decCtrl.sys;

    assign stageValid[0]     = accept;
    assign stageData[0]      = {decCtrl, tag_i};
    assign stageReady[DEPTH] = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : gStage
        ctrl_pipe_stage #(.W(W)) uStage (
            .clk      (clk),
            .reset_n  (reset_n),
            .flush    (flush),
            .inValid  (stageValid[k]),
            .inReady  (stageReady[k]),
            .inData   (stageData[k]),
            .outValid (stageValid[k+1]),
            .outReady (stageReady[k+1]),
            .outData  (stageData[k+1])
        );
    end

    // Empty output slots present an all-zero bundle and tag.
    assign out_valid = stageValid[DEPTH];
    assign outWord   = out_valid ? stageData[DEPTH] : '0;
    assign outCtrl   = ctrl_t'(outWord[W-1:TAG_W]);
    assign tag_o     = outWord[TAG_W-1:0];

    assign RegWrite  = outCtrl.regWrite;
    assign ImmSrc    = outCtrl.immSrc;
    assign ALUSrc    = outCtrl.aluSrc;
    assign ALUSrcA   = outCtrl.aluSrcA;
    assign MemWrite  = outCtrl.memWrite;
    assign ResultSrc = outCtrl.resultSrc;
    assign ALUOp     = outCtrl.aluOp;
    assign Jump      = outCtrl.jump;
    assign Jalr      = outCtrl.jalr;
    assign Branch    = outCtrl.branch;
    assign MulDiv    = outCtrl.mulDiv;
    assign Illegal   = outCtrl.illegal;
    assign Sys       = outCtrl.sys;

    // Issue state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= stateNext;
        end
    end

    // A trapping word stops issue only once it has actually been taken into the pipe.
    always_comb begin
        stateNext = state;
        halt      = 1'b0;
        case (state)
            ST_RUN: begin
                if (ILLEGAL_HALT && accept && trap) begin
                    stateNext = ST_HALT;
                end
            end
            ST_HALT: begin
                halt = 1'b1;
                if (resume || flush) begin
                    stateNext = ST_RUN;
                end
            end
            default: begin
                stateNext = ST_RUN;
            end
        endcase
    end

endmodule

// File: doc/ctrl_decode_pipe.md
Name: ctrl_decode_pipe

Overview:
Parametrised RV32I(+M) control decoder with a registered, back-pressured output pipeline between IF/ID and EX. It replaces the purely combinational opcode decode with:
- full instruction legality checks
- separate LUI/AUIPC handling
- an optional M-extension path
- a sideband tag (PC) carried alongside the controls
- a RUN/HALT state machine that stops issue after a trapping instruction.

Parameters:
DEPTH, 1, number of register stages between decode and outputs (legal range 1..4).
ENABLE_M, 1, decode funct7=0000001 R-type as mul/div; when 0 that encoding is illegal.
TAG_W, 32, width of the sideband tag (normally the PC).
ILLEGAL_HALT, 1, when 1 an illegal/ecall/ebreak instruction halts issue; when 0 it is only flagged.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
instr_i  in  32  instruction word
tag_i  in  TAG_W  sideband tag, e.g. PC
in_valid  in  1  instr_i/tag_i valid
in_ready  out  1  block accepts this cycle
flush  in  1  discard all in-flight entries
out_valid  out  1  output bundle valid
out_ready  in  1  downstream accepts
tag_o  out  TAG_W  tag of the output entry
RegWrite  out  1  register write enable
ImmSrc  out  3  immediate type: 000 I, 001 S, 010 B, 011 J, 100 U
ALUSrc  out  1  ALU B operand: 1 = immediate
ALUSrcA  out  1  ALU A operand: 1 = PC (AUIPC)
MemWrite  out  1  memory write enable
ResultSrc  out  2  result select: 00 ALU, 01 mem, 10 PC+4, 11 imm
ALUOp  out  2  00 add, 01 branch compare, 10 funct-decoded, 11 muldiv
Jump  out  1  JAL
Jalr  out  1  JALR
Branch  out  1  conditional branch
MulDiv  out  1  M-extension operation
Illegal  out  1  illegal instruction
Sys  out  1  ecall/ebreak
halt  out  1  block is in HALT state
resume  in  1  leave HALT

Behaviour:
- Reset (asynchronous, reset_n=0):
  - all stage valid bits cleared; state RUN
  - every control output, tag_o and out_valid = 0; halt = 0
- Decode table:
  - lw/lb/lh/lbu/lhu: RegWrite, ImmSrc=000, ALUSrc, ResultSrc=01, ALUOp=00
  - store: ImmSrc=001, ALUSrc, MemWrite
  - R-type: RegWrite, ALUOp=10
  - I-ALU: RegWrite, ALUSrc, ALUOp=10
  - branch: ImmSrc=010, ALUOp=01, Branch
  - LUI: RegWrite, ImmSrc=100, ResultSrc=11
  - AUIPC: RegWrite, ImmSrc=100, ALUSrcA, ALUSrc, ALUOp=00
  - JAL: RegWrite, ImmSrc=011, ResultSrc=10, Jump
  - JALR: RegWrite, ImmSrc=000, ALUSrc, ResultSrc=10, Jalr
  - FENCE: all zero, legal
  - ecall/ebreak: Sys=1
  - R-type funct7=0000001 with ENABLE_M=1: ALUOp=11, MulDiv=1
- Illegal (Illegal=1, all other controls 0) for any of:
  - instr[1:0] != 11
  - unknown opcode
  - load funct3 in {011,110,111}
  - store funct3 > 010
  - branch funct3 in {010,011}
  - JALR funct3 != 000
  - R-type funct7 not in {0000000, 0100000 (funct3 000/101 only), 0000001 (ENABLE_M)}
  - SYSTEM other than exact ecall/ebreak words
- Invalid output slots drive all controls 0; never X.
- Pipeline:
  - DEPTH stages, each holding {valid, ctrl bundle, tag}
  - stage k ready = !valid_k | ready_{k+1}; ready after the last stage = out_ready
  - in_ready = stage0 ready & state==RUN
  - latency = DEPTH cycles from acceptance to out_valid with no back-pressure; throughput 1/cycle
  - out_valid held with stable outputs while out_ready=0
- flush: all valid bits cleared at the next edge; input is not accepted that cycle; flush wins over a simultaneous accept.
- FSM (state RUN/HALT):
  - RUN→HALT when an entry with Illegal|Sys is accepted into stage0, ILLEGAL_HALT=1 and flush=0
  - in HALT: in_ready=0, halt=1; in-flight entries, including the trapping one, still drain
  - HALT→RUN on resume=1 or flush=1
  - resume while in RUN: ignored
  - ILLEGAL_HALT=0: never enters HALT; flags pass through
- Simultaneous accept at stage0 and drain of the last stage in the same cycle is legal and keeps full throughput.

Decomposition:
- Shared package ctrl_pkg:
  - opcode constants
  - ImmSrc, ResultSrc and ALUOp encodings
  - control bundle struct/width
  - RUN/HALT state encoding
- Sub-modules:
  - ctrl_decode_comb: purely combinational instruction → bundle decode
  - ctrl_pipe_stage: one valid/ready register, instantiated DEPTH times by generate

Test Plan:
- DEPTH=2, lw 0x00412083 at t0, out_ready=1 → out_valid at t0+2: RegWrite=1, ImmSrc=000, ALUSrc=1, ResultSrc=01, ALUOp=00; tag_o = tag_i.
- Stream 6 back-to-back instructions with out_ready low for cycles 3-5 → in_ready drops once stages are full, no loss or duplication, order preserved.
- LUI 0x123450B7 then AUIPC 0x00001097 → ResultSrc=11/ImmSrc=100; then ALUSrcA=1, ALUSrc=1, ResultSrc=00.
- Instr 0xFFFFFFFF accepted → Illegal=1 at output, halt=1 from the next cycle, in_ready=0; resume pulse → RUN, acceptance restarts.
- MUL 0x02208033 with ENABLE_M=1 → ALUOp=11, MulDiv=1; same instruction with ENABLE_M=0 → Illegal=1.
- Flush with all stages full plus a simultaneous accept → out_valid=0 next cycle, accepted word dropped; reset_n low mid-stream → all outputs 0 asynchronously.
